// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sequencing one core access at a time onto the single-port dmem.
// gnt one cycle after req is sampled; read data returns as rvalid two cycles after gnt.
module dmem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 8,
  parameter int DW      = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [0:NUM_REQ-1]      req,
  input  logic [0:NUM_REQ-1]      wr,
  input  logic [0:AW*NUM_REQ-1]   addr,
  input  logic [0:DW*NUM_REQ-1]   wdata,
  output logic [0:NUM_REQ-1]      gnt,
  output logic [0:NUM_REQ-1]      rvalid,
  output logic [0:DW-1]           rdata,
  output logic                    busy,
  output logic                    mem_en,
  output logic                    mem_wr_en,
  output logic [0:AW-1]           mem_addr,
  output logic [0:DW-1]           mem_dout,
  input  logic [0:DW-1]           mem_din
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              r_state;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_win;
  logic                r_wr;

  logic                w_any;
  logic [PW-1:0]       w_win;
  logic [PW-1:0]       w_next_ptr;
  logic                w_wr;
  logic [0:AW-1]       w_addr;
  logic [0:DW-1]       w_wdata;
  logic [0:NUM_REQ-1]  w_gnt_oh;
  logic [0:NUM_REQ-1]  w_rv_oh;

  // Two passes give the wrap-around scan: indices at/after ptr first, then the rest.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_any && req[i] && (PW'(i) >= r_ptr)) begin
        w_any = 1'b1;
        w_win = PW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_any && req[i]) begin
        w_any = 1'b1;
        w_win = PW'(i);
      end
    end
    w_next_ptr = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  end

  always_comb begin
    w_wr     = 1'b0;
    w_addr   = '0;
    w_wdata  = '0;
    w_gnt_oh = '0;
    w_rv_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == w_win) begin
        w_wr        = wr[i];
        w_addr      = addr[AW*i +: AW];
        w_wdata     = wdata[DW*i +: DW];
        w_gnt_oh[i] = 1'b1;
      end
      if (PW'(i) == r_win) begin
        w_rv_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_win     <= '0;
      r_wr      <= 1'b0;
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_dout  <= '0;
    end else begin
      gnt       <= '0;
      rvalid    <= '0;
      mem_en    <= 1'b0;
      mem_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state   <= ACCESS;
            r_win     <= w_win;
            r_wr      <= w_wr;
            r_ptr     <= w_next_ptr;
            mem_en    <= 1'b1;
            mem_wr_en <= w_wr;
            mem_addr  <= w_addr;
            mem_dout  <= w_wdata;
            gnt       <= w_gnt_oh;
            busy      <= 1'b1;
          end
        end
        ACCESS: begin
          if (r_wr) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_state <= RESP;
          end
        end
        RESP: begin
          // dmem registered the read at the ACCESS edge, so mem_din is valid now.
          rdata   <= mem_din;
          rvalid  <= w_rv_oh;
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous-read dmem.
module tb_dmem_arbiter;
  localparam int NUM_REQ = 4;
  localparam int AW      = 8;
  localparam int DW      = 64;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [0:NUM_REQ-1]     req, wr, gnt, rvalid;
  logic [0:AW*NUM_REQ-1]  addr;
  logic [0:DW*NUM_REQ-1]  wdata;
  logic [0:DW-1]          rdata, mem_dout, mem_din;
  logic                   busy, mem_en, mem_wr_en;
  logic [0:AW-1]          mem_addr;
  logic [0:DW-1]          mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_din(mem_din)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) mem[mem_addr] <= mem_dout;
      else           mem_din <= mem[mem_addr];
    end
  end

  function automatic logic [0:NUM_REQ-1] onehot(input int i);
    logic [0:NUM_REQ-1] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input int i, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]            = r;
    wr[i]             = w;
    addr[AW*i +: AW]  = a;
    wdata[DW*i +: DW] = d;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    wr    = '0;
    addr  = '0;
    wdata = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    wr    = '0;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h20] = 64'h0123456789ABCDEF;
    mem[8'h05] = 64'hA5A5A5A55A5A5A5A;

    // reset state
    #2;
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_rvalid", 64'(rvalid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_mem_en", 64'(mem_en), 64'h0);
    check("rst_mem_wr_en", 64'(mem_wr_en), 64'h0);
    check("rst_rdata", 64'(rdata), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_mem_dout", 64'(mem_dout), 64'h0);
    step();
    reset = 1'b1;

    // single write from core 1
    set_core(1, 1'b1, 1'b1, 8'h10, 64'hDEADBEEF00000001);
    step();
    check("wr_gnt", 64'(gnt), 64'(onehot(1)));
    check("wr_mem_en", 64'(mem_en), 64'h1);
    check("wr_mem_wr_en", 64'(mem_wr_en), 64'h1);
    check("wr_mem_addr", 64'(mem_addr), 64'h10);
    check("wr_mem_dout", 64'(mem_dout), 64'hDEADBEEF00000001);
    check("wr_busy", 64'(busy), 64'h1);
    set_core(1, 1'b0, 1'b0, 8'h00, 64'h0);
    step();
    check("wr_gnt_off", 64'(gnt), 64'h0);
    check("wr_rvalid", 64'(rvalid), 64'h0);
    check("wr_mem_en_off", 64'(mem_en), 64'h0);
    check("wr_busy_off", 64'(busy), 64'h0);
    check("wr_mem", 64'(mem[8'h10]), 64'hDEADBEEF00000001);
    step();
    check("wr_rvalid2", 64'(rvalid), 64'h0);

    // single read from core 2
    set_core(2, 1'b1, 1'b0, 8'h20, 64'h0);
    step();
    check("rd_gnt", 64'(gnt), 64'(onehot(2)));
    check("rd_mem_en", 64'(mem_en), 64'h1);
    check("rd_mem_wr_en", 64'(mem_wr_en), 64'h0);
    check("rd_mem_addr", 64'(mem_addr), 64'h20);
    set_core(2, 1'b0, 1'b0, 8'h00, 64'h0);
    step();
    check("rd_resp_busy", 64'(busy), 64'h1);
    check("rd_resp_mem_en", 64'(mem_en), 64'h0);
    check("rd_resp_rvalid", 64'(rvalid), 64'h0);
    check("rd_resp_gnt", 64'(gnt), 64'h0);
    step();
    check("rd_rvalid", 64'(rvalid), 64'(onehot(2)));
    check("rd_rdata", 64'(rdata), 64'h0123456789ABCDEF);
    check("rd_busy_off", 64'(busy), 64'h0);
    step();
    check("rd_rvalid_off", 64'(rvalid), 64'h0);
    check("rd_rdata_hold", 64'(rdata), 64'h0123456789ABCDEF);

    // round-robin with all cores writing continuously, from ptr=0
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_core(i, 1'b1, 1'b1, 8'(8'h30 + i), 64'(64'h1000 + i));
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("rr_gnt%0d", k), 64'(gnt), 64'(onehot(k % NUM_REQ)));
      step();
      check($sformatf("rr_gap%0d", k), 64'(gnt), 64'h0);
      if (k == 5) req = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) check($sformatf("rr_mem%0d", i), 64'(mem[8'h30 + i]), 64'(64'h1000 + i));

    // core 2 alone moves ptr to 3, then cores 0 and 3 compete
    set_core(2, 1'b1, 1'b1, 8'h40, 64'h2222);
    step();
    check("rr_c2_gnt", 64'(gnt), 64'(onehot(2)));
    req = '0;
    step();
    set_core(0, 1'b1, 1'b1, 8'h41, 64'h0000);
    set_core(3, 1'b1, 1'b1, 8'h43, 64'h3333);
    step();
    check("rr_c3_first", 64'(gnt), 64'(onehot(3)));
    req[3] = 1'b0;
    step();
    check("rr_c3_gap", 64'(gnt), 64'h0);
    step();
    check("rr_c0_second", 64'(gnt), 64'(onehot(0)));
    req = '0;
    step();

    // mixed read then write, back-to-back
    do_reset();
    set_core(0, 1'b1, 1'b0, 8'h05, 64'h0);
    set_core(1, 1'b1, 1'b1, 8'h06, 64'hCAFEF00D12345678);
    step();
    check("mx_c1_gnt0", 64'(gnt), 64'(onehot(0)));
    check("mx_c1_addr", 64'(mem_addr), 64'h05);
    req[0] = 1'b0;
    step();
    check("mx_c2_gnt", 64'(gnt), 64'h0);
    check("mx_c2_busy", 64'(busy), 64'h1);
    step();
    check("mx_c3_rvalid0", 64'(rvalid), 64'(onehot(0)));
    check("mx_c3_rdata", 64'(rdata), 64'hA5A5A5A55A5A5A5A);
    check("mx_c3_gnt", 64'(gnt), 64'h0);
    step();
    check("mx_c4_gnt1", 64'(gnt), 64'(onehot(1)));
    check("mx_c4_rvalid", 64'(rvalid), 64'h0);
    check("mx_c4_wr_en", 64'(mem_wr_en), 64'h1);
    check("mx_c4_addr", 64'(mem_addr), 64'h06);
    req = '0;
    step();
    check("mx_c5_busy", 64'(busy), 64'h0);
    check("mx_c5_mem", 64'(mem[8'h06]), 64'hCAFEF00D12345678);

    // reset asserted during RESP of a core-2 read (ptr=2 here)
    set_core(2, 1'b1, 1'b0, 8'h20, 64'h0);
    step();
    check("mr_gnt", 64'(gnt), 64'(onehot(2)));
    req = '0;
    step();
    check("mr_resp_busy", 64'(busy), 64'h1);
    reset = 1'b0;
    #1;
    check("mr_mem_en", 64'(mem_en), 64'h0);
    check("mr_gnt0", 64'(gnt), 64'h0);
    check("mr_rvalid", 64'(rvalid), 64'h0);
    check("mr_busy", 64'(busy), 64'h0);
    check("mr_rdata", 64'(rdata), 64'h0);
    step();
    reset = 1'b1;
    step();
    check("mr_no_rvalid", 64'(rvalid), 64'h0);
    set_core(1, 1'b1, 1'b1, 8'h50, 64'h5151);
    set_core(3, 1'b1, 1'b1, 8'h53, 64'h5353);
    step();
    check("mr_first_gnt", 64'(gnt), 64'(onehot(1)));
    check("mr_first_rvalid", 64'(rvalid), 64'h0);
    req = '0;
    step();

    // idle for 10 cycles, ptr sits at 2
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("idle_mem_en%0d", k), 64'(mem_en), 64'h0);
      check($sformatf("idle_busy%0d", k), 64'(busy), 64'h0);
      check($sformatf("idle_gnt%0d", k), 64'(gnt), 64'h0);
    end
    for (int i = 0; i < NUM_REQ; i++) set_core(i, 1'b1, 1'b1, 8'(8'h60 + i), 64'h0);
    step();
    check("idle_ptr_kept", 64'(gnt), 64'(onehot(2)));
    req = '0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
